config_mem_loader: RTL and testbench

//  Programs the neuron configuration memories. It receives configuration packets as a stream of AER-width words

---
 rtl/config_mem_loader_if.sv | 42 ++++
 rtl/config_mem_loader.sv | 171 +++++++++++++++++
 tb/tb_config_mem_loader.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/config_mem_loader_if.sv
// Bundles the configuration word stream and the A/B/C config write ports of the loader.
// Latency: none (wiring only).
// Backpressure: the slave drives cfgReady_o, and the master holds cfgData_i/cfgValid_i until that word is accepted.
interface config_mem_loader_if #(
  parameter int DSIZE              = 16,
  parameter int NURN_CNT_BIT_WIDTH = 8,
  parameter int AXON_CNT_BIT_WIDTH = 8,
  parameter int STDP_WIN_BIT_WIDTH = 8,
  parameter int AER_BIT_WIDTH      = 32
);
  localparam int MWA = 2*STDP_WIN_BIT_WIDTH + 2*DSIZE + 1;
  localparam int MWB = 2 + 2*DSIZE + AER_BIT_WIDTH;
  localparam int CAW = NURN_CNT_BIT_WIDTH + AXON_CNT_BIT_WIDTH;

  logic [AER_BIT_WIDTH-1:0]      cfgData_i;
  logic                          cfgValid_i;
  logic                          cfgReady_o;
  logic                          wrEn_A_o;
  logic [NURN_CNT_BIT_WIDTH-1:0] wrAddr_A_o;
  logic [MWA-1:0]                wrData_A_o;
  logic                          wrEn_B_o;
  logic [NURN_CNT_BIT_WIDTH-1:0] wrAddr_B_o;
  logic [MWB-1:0]                wrData_B_o;
  logic                          wrEn_C_o;
  logic [CAW-1:0]                wrAddr_C_o;
  logic                          wrData_C_o;
  logic                          busy_o;
  logic                          done_o;
  logic                          err_o;

  modport master (
    output cfgData_i, cfgValid_i,
    input  cfgReady_o, wrEn_A_o, wrAddr_A_o, wrData_A_o, wrEn_B_o, wrAddr_B_o, wrData_B_o,
           wrEn_C_o, wrAddr_C_o, wrData_C_o, busy_o, done_o, err_o
  );

  modport slave (
    input  cfgData_i, cfgValid_i,
    output cfgReady_o, wrEn_A_o, wrAddr_A_o, wrData_A_o, wrEn_B_o, wrAddr_B_o, wrData_B_o,
           wrEn_C_o, wrAddr_C_o, wrData_C_o, busy_o, done_o, err_o
  );
endinterface

// File: rtl/config_mem_loader.sv
// Decodes config packets (header + payload words) and writes entries into neuron config memories A, B and C.
// Latency: the write strobe fires 1 cycle after the last word of an entry is accepted; done_o pulses on the next cycle.
// Backpressure: cfgReady_o is low during WRITE, DONE and reset, and a low cfgValid_i simply holds the current state.
module config_mem_loader #(
  parameter int NUM_NURNS          = 256,
  parameter int NUM_AXONS          = 256,
  parameter int DSIZE              = 16,
  parameter int NURN_CNT_BIT_WIDTH = 8,
  parameter int AXON_CNT_BIT_WIDTH = 8,
  parameter int STDP_WIN_BIT_WIDTH = 8,
  parameter int AER_BIT_WIDTH      = 32
) (
  input logic                clk_i,
  input logic                rst_n_i,
  config_mem_loader_if.slave bus
);
  localparam int W     = AER_BIT_WIDTH;
  localparam int MWA   = 2*STDP_WIN_BIT_WIDTH + 2*DSIZE + 1;
  localparam int MWB   = 2 + 2*DSIZE + W;
  localparam int WPE_A = (MWA + W - 1) / W;
  localparam int WPE_B = (MWB + W - 1) / W;
  localparam int MAXW  = (WPE_A > WPE_B) ? WPE_A : WPE_B;
  localparam int EW    = MAXW * W;
  localparam int IW    = $clog2(MAXW + 1);
  localparam int CAW   = NURN_CNT_BIT_WIDTH + AXON_CNT_BIT_WIDTH;
  // The address field occupies the bits between sel and the count, capped at 16 bits, so narrow words
  // never overlap it with the count field.
  localparam int AFW   = (W - 18 < 16) ? W - 18 : 16;
  // The internal address counter is wide enough that start address + count can never wrap.
  localparam int XAW   = 18;
  localparam logic [XAW-1:0] LIM_AB = XAW'(NUM_NURNS);
  localparam logic [XAW-1:0] LIM_C  = XAW'(NUM_NURNS * NUM_AXONS);

  typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;

  state_t         state;
  logic [1:0]     sel;
  logic [XAW-1:0] cur_addr;
  logic [15:0]    cnt;
  logic [IW-1:0]  widx;
  logic [EW-1:0]  ent;

  logic [1:0]     hdr_sel;
  logic [XAW-1:0] hdr_addr;
  logic [15:0]    hdr_cnt;
  logic           accept;
  logic [IW-1:0]  wpe_cur;
  logic           last_word;
  logic           in_range;
  logic [EW-1:0]  ent_nx;
  logic           unused_ent_bits;

  assign hdr_sel  = bus.cfgData_i[W-1 -: 2];
  assign hdr_addr = XAW'(bus.cfgData_i[W-3 -: AFW]);
  assign hdr_cnt  = bus.cfgData_i[15:0];

  assign bus.cfgReady_o = rst_n_i && ((state == IDLE) || (state == COLLECT));
  assign bus.busy_o     = (state != IDLE);
  assign accept         = bus.cfgValid_i && bus.cfgReady_o;

  // Words per entry for the memory selected by the current packet; C always takes a single word.
  always_comb begin
    wpe_cur = IW'(1);
    case (sel)
      2'd0:    wpe_cur = IW'(WPE_A);
      2'd1:    wpe_cur = IW'(WPE_B);
      default: wpe_cur = IW'(1);
    endcase
  end

  assign last_word = (widx == wpe_cur - IW'(1));
  assign in_range  = (sel == 2'd2) ? (cur_addr < LIM_C) : (cur_addr < LIM_AB);

  // Entry image including the word currently on the bus, packed with word k at bits [k*W +: W].
  always_comb begin
    ent_nx = ent;
    ent_nx[int'(widx)*W +: W] = bus.cfgData_i;
  end

  // Bits above the widest entry are collected here and intentionally left unused.
  assign unused_ent_bits = ^ent_nx;

  // Packet FSM: header decode, word assembly, registered write strobes, done pulse and sticky error.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state          <= IDLE;
      sel            <= 2'd0;
      cur_addr       <= '0;
      cnt            <= '0;
      widx           <= '0;
      ent            <= '0;
      bus.wrEn_A_o   <= 1'b0;
      bus.wrAddr_A_o <= '0;
      bus.wrData_A_o <= '0;
      bus.wrEn_B_o   <= 1'b0;
      bus.wrAddr_B_o <= '0;
      bus.wrData_B_o <= '0;
      bus.wrEn_C_o   <= 1'b0;
      bus.wrAddr_C_o <= '0;
      bus.wrData_C_o <= 1'b0;
      bus.done_o     <= 1'b0;
      bus.err_o      <= 1'b0;
    end else begin
      bus.wrEn_A_o <= 1'b0;
      bus.wrEn_B_o <= 1'b0;
      bus.wrEn_C_o <= 1'b0;
      bus.done_o   <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (hdr_sel == 2'd3 || hdr_cnt == 16'd0) begin
              bus.err_o <= 1'b1;
            end else begin
              sel      <= hdr_sel;
              cur_addr <= hdr_addr;
              cnt      <= hdr_cnt;
              widx     <= '0;
              state    <= COLLECT;
            end
          end
        end
        COLLECT: begin
          if (accept) begin
            ent <= ent_nx;
            if (last_word) begin
              widx  <= '0;
              state <= WRITE;
              if (in_range) begin
                case (sel)
                  2'd0: begin
                    bus.wrEn_A_o   <= 1'b1;
                    bus.wrAddr_A_o <= cur_addr[NURN_CNT_BIT_WIDTH-1:0];
                    bus.wrData_A_o <= ent_nx[MWA-1:0];
                  end
                  2'd1: begin
                    bus.wrEn_B_o   <= 1'b1;
                    bus.wrAddr_B_o <= cur_addr[NURN_CNT_BIT_WIDTH-1:0];
                    bus.wrData_B_o <= ent_nx[MWB-1:0];
                  end
                  default: begin
                    bus.wrEn_C_o   <= 1'b1;
                    bus.wrAddr_C_o <= cur_addr[CAW-1:0];
                    bus.wrData_C_o <= ent_nx[0];
                  end
                endcase
              end else begin
                bus.err_o <= 1'b1;
              end
            end else begin
              widx <= widx + IW'(1);
            end
          end
        end
        WRITE: begin
          cur_addr <= cur_addr + XAW'(1);
          cnt      <= cnt - 16'd1;
          if (cnt == 16'd1) begin
            bus.done_o <= 1'b1;
            state      <= DONE;
          end else begin
            state <= COLLECT;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_config_mem_loader.sv
// Directed bench for config_mem_loader: per-scenario tasks with inline comparisons against hand-computed values.
// Stimulus words are presented on posedge+1 and outputs are sampled on the falling edge.
// A passive monitor logs every write strobe and done pulse for the scenario tasks to inspect.
module tb_config_mem_loader;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  config_mem_loader_if b ();
  config_mem_loader dut (.clk_i(clk), .rst_n_i(rst_n), .bus(b));

  typedef struct {
    logic [1:0]  sel;
    logic [15:0] addr;
    logic [65:0] data;
  } wr_t;

  wr_t wlog[$];
  int  done_cnt  = 0;
  int  multi_cnt = 0;
  int  errors    = 0;
  int  checks    = 0;

  function automatic wr_t mk(input logic [1:0] s, input logic [15:0] a, input logic [65:0] d);
    wr_t e;
    e.sel = s; e.addr = a; e.data = d;
    return e;
  endfunction

  function automatic logic [31:0] hdr(input logic [1:0] s, input logic [13:0] a, input logic [15:0] n);
    return {s, a, n};
  endfunction

  // Passive monitor of strobes, done pulses and strobe exclusivity.
  always @(negedge clk) begin
    if (rst_n) begin
      if (b.wrEn_A_o) wlog.push_back(mk(2'd0, 16'(b.wrAddr_A_o), 66'(b.wrData_A_o)));
      if (b.wrEn_B_o) wlog.push_back(mk(2'd1, 16'(b.wrAddr_B_o), b.wrData_B_o));
      if (b.wrEn_C_o) wlog.push_back(mk(2'd2, b.wrAddr_C_o, 66'(b.wrData_C_o)));
      if ((int'(b.wrEn_A_o) + int'(b.wrEn_B_o) + int'(b.wrEn_C_o)) > 1) multi_cnt++;
      if (b.done_o) done_cnt++;
    end
  end

  task automatic send(input logic [31:0] w, input int gap);
    int  n;
    logic r;
    @(posedge clk); #1;
    b.cfgValid_i = 1'b0;
    for (int i = 0; i < gap; i++) begin
      b.cfgData_i = $urandom;
      @(posedge clk); #1;
    end
    b.cfgData_i  = w;
    b.cfgValid_i = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      r = b.cfgReady_o;
      @(posedge clk); #1;
      n++;
    end while (r !== 1'b1 && n < 20);
    b.cfgValid_i = 1'b0;
    checks++;
    if (r !== 1'b1) begin errors++; $display("FAIL send_timeout: ready=%b required 1", r); end
  endtask

  task automatic do_reset();
    b.cfgValid_i = 1'b0;
    @(negedge clk); rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    wlog.delete(); done_cnt = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; b.cfgValid_i = 1'b0; b.cfgData_i = '0;
    repeat (2) @(negedge clk);
    checks++; if (b.cfgReady_o !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b required 0", b.cfgReady_o); end
    checks++; if ({b.busy_o, b.done_o, b.err_o} !== 3'b000) begin errors++; $display("FAIL rst_flags: got %b required 000", {b.busy_o, b.done_o, b.err_o}); end
    checks++; if ({b.wrEn_A_o, b.wrEn_B_o, b.wrEn_C_o} !== 3'b000) begin errors++; $display("FAIL rst_wren: got %b required 000", {b.wrEn_A_o, b.wrEn_B_o, b.wrEn_C_o}); end
    checks++; if ({b.wrAddr_A_o, b.wrData_A_o, b.wrData_B_o, b.wrAddr_C_o} !== '0) begin errors++; $display("FAIL rst_addr_data: nonzero, required 0"); end
    rst_n = 1'b1; #1;
    checks++; if (b.cfgReady_o !== 1'b1) begin errors++; $display("FAIL rel_ready: got %b required 1", b.cfgReady_o); end
    @(negedge clk);
    checks++; if (b.busy_o !== 1'b0) begin errors++; $display("FAIL rel_busy: got %b required 0", b.busy_o); end
    wlog.delete(); done_cnt = 0;
  endtask

  task automatic test_write_a();
    send(hdr(2'd0, 14'd5, 16'd1), 0);
    send(32'h0000_0001, 0);
    send(32'h0000_0002, 0);
    @(negedge clk);
    checks++; if (b.wrEn_A_o !== 1'b1) begin errors++; $display("FAIL a_wren: got %b required 1", b.wrEn_A_o); end
    checks++; if (b.wrAddr_A_o !== 8'd5) begin errors++; $display("FAIL a_addr: got %0d required 5", b.wrAddr_A_o); end
    checks++; if (b.wrData_A_o !== 49'h2_0000_0001) begin errors++; $display("FAIL a_data: got %h required 2_0000_0001", b.wrData_A_o); end
    checks++; if (b.cfgReady_o !== 1'b0) begin errors++; $display("FAIL a_write_ready: got %b required 0", b.cfgReady_o); end
    @(negedge clk);
    checks++; if ({b.done_o, b.wrEn_A_o, b.busy_o} !== 3'b101) begin errors++; $display("FAIL a_done: got done/wr/busy=%b required 101", {b.done_o, b.wrEn_A_o, b.busy_o}); end
    @(negedge clk);
    checks++; if ({b.busy_o, b.done_o, b.err_o} !== 3'b000) begin errors++; $display("FAIL a_idle: got busy/done/err=%b required 000", {b.busy_o, b.done_o, b.err_o}); end
    checks++; if (b.wrAddr_A_o !== 8'd5) begin errors++; $display("FAIL a_addr_hold: got %0d required 5", b.wrAddr_A_o); end
    checks++; if (wlog.size() != 1 || done_cnt != 1) begin errors++; $display("FAIL a_counts: writes=%0d dones=%0d required 1 1", wlog.size(), done_cnt); end
  endtask

  task automatic test_gaps();
    wlog.delete(); done_cnt = 0;
    send(hdr(2'd0, 14'd5, 16'd1), $urandom_range(0, 3));
    send(32'h0000_0001, $urandom_range(1, 4));
    send(32'h0000_0002, $urandom_range(1, 4));
    repeat (4) @(negedge clk);
    checks++;
    if (wlog.size() != 1) begin errors++; $display("FAIL gap_count: got %0d writes required 1", wlog.size()); end
    else if (wlog[0].sel !== 2'd0 || wlog[0].addr !== 16'd5 || wlog[0].data !== 66'h2_0000_0001) begin
      errors++; $display("FAIL gap_write: got sel=%0d addr=%0d data=%h required 0 5 2_0000_0001", wlog[0].sel, wlog[0].addr, wlog[0].data);
    end
    checks++; if (done_cnt != 1 || b.busy_o !== 1'b0) begin errors++; $display("FAIL gap_done: dones=%0d busy=%b required 1 0", done_cnt, b.busy_o); end
  endtask

  task automatic test_c();
    logic [3:0] bits;
    bits = 4'b1101;
    wlog.delete(); done_cnt = 0;
    send(hdr(2'd2, 14'h0102, 16'd4), 0);
    for (int i = 0; i < 4; i++) begin
      send(32'hFFFF_FFFE | 32'(bits[i]), 0);
      @(negedge clk);
      checks++;
      if (b.wrEn_C_o !== 1'b1 || b.wrAddr_C_o !== 16'(16'h0102 + i) || b.wrData_C_o !== bits[i] || b.cfgReady_o !== 1'b0) begin
        errors++;
        $display("FAIL c_entry%0d: got en=%b addr=%h data=%b ready=%b required 1 %h %b 0", i, b.wrEn_C_o, b.wrAddr_C_o, b.wrData_C_o, b.cfgReady_o, 16'h0102 + i, bits[i]);
      end
    end
    @(negedge clk);
    checks++; if (b.done_o !== 1'b1) begin errors++; $display("FAIL c_done: got %b required 1", b.done_o); end
    checks++; if (wlog.size() != 4 || b.err_o !== 1'b0) begin errors++; $display("FAIL c_totals: writes=%0d err=%b required 4 0", wlog.size(), b.err_o); end
  endtask

  task automatic test_reset_mid();
    wlog.delete(); done_cnt = 0;
    send(hdr(2'd0, 14'd7, 16'd1), 0);
    send(32'h1234_5678, 0);
    @(negedge clk); rst_n = 1'b0; #1;
    checks++; if ({b.cfgReady_o, b.busy_o} !== 2'b00) begin errors++; $display("FAIL mid_rst_flags: ready/busy=%b required 00", {b.cfgReady_o, b.busy_o}); end
    checks++; if (b.wrAddr_A_o !== 8'd0 || b.wrData_A_o !== 49'd0) begin errors++; $display("FAIL mid_rst_clear: addr=%0d data=%h required 0 0", b.wrAddr_A_o, b.wrData_A_o); end
    @(negedge clk); rst_n = 1'b1; #1;
    checks++; if (b.cfgReady_o !== 1'b1) begin errors++; $display("FAIL mid_rel_ready: got %b required 1", b.cfgReady_o); end
    repeat (3) @(negedge clk);
    checks++; if (wlog.size() != 0 || b.busy_o !== 1'b0) begin errors++; $display("FAIL mid_nowrite: writes=%0d busy=%b required 0 0", wlog.size(), b.busy_o); end
    send(hdr(2'd0, 14'd9, 16'd1), 0);
    send(32'h0000_000A, 0);
    send(32'h0000_000B, 0);
    @(negedge clk);
    checks++; if (b.wrEn_A_o !== 1'b1 || b.wrAddr_A_o !== 8'd9 || b.wrData_A_o !== 49'h000B_0000_000A) begin
      errors++; $display("FAIL fresh_write: en=%b addr=%0d data=%h required 1 9 000B_0000_000A", b.wrEn_A_o, b.wrAddr_A_o, b.wrData_A_o);
    end
  endtask

  task automatic test_bad_headers();
    do_reset();
    send(32'hC000_0001, 0);
    @(negedge clk);
    checks++; if ({b.err_o, b.busy_o} !== 2'b10) begin errors++; $display("FAIL bad_sel: err/busy=%b required 10", {b.err_o, b.busy_o}); end
    do_reset();
    send(hdr(2'd0, 14'd5, 16'd0), 0);
    @(negedge clk);
    checks++; if ({b.err_o, b.busy_o} !== 2'b10) begin errors++; $display("FAIL bad_n0: err/busy=%b required 10", {b.err_o, b.busy_o}); end
    repeat (3) @(negedge clk);
    checks++; if (wlog.size() != 0 || done_cnt != 0 || b.busy_o !== 1'b0) begin errors++; $display("FAIL bad_quiet: writes=%0d dones=%0d busy=%b required 0 0 0", wlog.size(), done_cnt, b.busy_o); end
  endtask

  task automatic test_b_range();
    do_reset();
    send(hdr(2'd1, 14'd254, 16'd3), 0);
    for (int k = 1; k <= 9; k++) begin
      send(32'h1111_1111 * k, 0);
      if (k == 6) begin
        @(negedge clk);
        checks++; if (b.err_o !== 1'b0) begin errors++; $display("FAIL b_err_early: got %b required 0", b.err_o); end
      end
    end
    @(negedge clk);
    checks++; if (b.wrEn_B_o !== 1'b0 || b.err_o !== 1'b1) begin errors++; $display("FAIL b_suppress: en=%b err=%b required 0 1", b.wrEn_B_o, b.err_o); end
    @(negedge clk);
    checks++; if (b.done_o !== 1'b1) begin errors++; $display("FAIL b_done: got %b required 1", b.done_o); end
    @(negedge clk);
    checks++; if (b.busy_o !== 1'b0 || b.wrAddr_B_o !== 8'd255) begin errors++; $display("FAIL b_after: busy=%b addr=%0d required 0 255", b.busy_o, b.wrAddr_B_o); end
    checks++;
    if (wlog.size() != 2) begin errors++; $display("FAIL b_count: got %0d writes required 2", wlog.size()); end
    else if (wlog[0].addr !== 16'd254 || wlog[0].data !== 66'h3_2222_2222_1111_1111 ||
             wlog[1].addr !== 16'd255 || wlog[1].data !== 66'h2_5555_5555_4444_4444) begin
      errors++; $display("FAIL b_writes: got %0d:%h %0d:%h required 254:3_2222_2222_1111_1111 255:2_5555_5555_4444_4444",
                         wlog[0].addr, wlog[0].data, wlog[1].addr, wlog[1].data);
    end
  endtask

  task automatic test_one_hot();
    checks++; if (multi_cnt != 0) begin errors++; $display("FAIL one_hot: %0d cycles with multiple strobes, required 0", multi_cnt); end
  endtask

  initial begin
    b.cfgValid_i = 1'b0;
    b.cfgData_i  = '0;
    test_reset();
    test_write_a();
    test_gaps();
    test_c();
    test_reset_mid();
    test_bad_headers();
    test_b_range();
    test_one_hot();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
